relu_maxpool_stage: RTL and testbench
=====================================

Name: relu_maxpool_stage

Overview:
- Downstream neighbour of the convolver: consumes its feature-map stream and produces a 2x2/stride-2 max-pooled map.
- Input is one signed DATA_WIDTH sample per accept, raster order, FEAT_SIZE x FEAT_SIZE, where FEAT_SIZE = IMAGE_SIZE-KERNEL_SIZE+1 (24 at defaults).
- Applies optional ReLU, then pools, and emits (FEAT_SIZE/2)^2 samples (144 at defaults) over a valid/ready interface to the next layer.

Parameters:
- DATA_WIDTH, 16, sample width, signed two's complement.
- IMAGE_SIZE, 28, input image edge length of the feeding convolver.
- KERNEL_SIZE, 5, convolver kernel edge length. FEAT_SIZE is derived and must be even; elaboration error otherwise.
- RELU_EN, 1, 1 = clamp negatives to 0 before pooling; 0 = pure max-pool.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort. Returns counters to frame start and drops any pending output.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  stage can accept a sample.
- in_data  input  DATA_WIDTH  feature-map sample, signed.
- out_valid  output  1  pooled sample valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  pooled sample, signed.
- out_last  output  1  qualifies the final pooled sample of a frame.

Behaviour:
- One clock domain. Reset is asynchronous, active-low.
- Reset state:
  - out_valid=0, out_data=0, out_last=0.
  - col, row counters = 0; hold register = 0.
  - Row buffer contents are don't-care; they are always written before being read.
- in_ready = !out_valid || out_ready (combinational). Reads 1 after reset.
- Accept = in_valid && in_ready. Every accept advances col. When col wraps from FEAT_SIZE-1 to 0, row advances. row wraps from FEAT_SIZE-1 to 0, so back-to-back frames need no gap.
- ReLU (RELU_EN=1): v = in_data[MSB] ? 0 : in_data. All comparisons are signed.
- Even col: hold <= v.
- Odd col: m = max(hold, v).
  - Even row: rowbuf[col>>1] <= m. The row buffer holds FEAT_SIZE/2 entries of DATA_WIDTH.
  - Odd row: out_data <= max(rowbuf[col>>1], m) and out_valid <= 1 on the next edge, so latency is 1 cycle from the completing accept.
  - out_last <= 1 on the same edge iff row=col=FEAT_SIZE-1.
- Output handshake:
  - out_valid, out_data and out_last hold stable until out_valid && out_ready.
  - On transfer with no new result, out_valid and out_last clear.
  - Transfer and new result in the same cycle: the register reloads, out_valid stays 1. Full throughput, no bubble.
- Stall while out_valid && !out_ready: in_ready=0, no accepts, counters frozen.
- clear=1:
  - Next edge: col=row=0, out_valid=0, out_last=0.
  - A simultaneous accept is discarded; clear wins.
  - A simultaneous output transfer is still counted as delivered by downstream.
- rstn deasserted mid-frame: immediate return to the reset state. The partial frame is lost and the next accepted sample is pixel (0,0).
- No overflow is possible: results are selected, never summed, so width stays DATA_WIDTH.

Test Plan:
- Ramp frame, in_data = row*24+col, out_ready=1 -> 144 outputs equal to (2r+1)*24+(2c+1). First is 25, second 27, last 575. out_last=1 only on the 144th.
- Frame of all-negative values (-1 to -576), RELU_EN=1 -> 144 outputs all 0. Same frame with RELU_EN=0 -> first output -1.
- Signed window: pixels (0,0)=-5, (0,1)=3, (1,0)=7, (1,1)=-100 -> first output 7. Window {-1,-2,-3,-4} -> 0 with RELU_EN=1 and -1 with RELU_EN=0.
- Backpressure: ramp frame, out_ready held 0 for 10 cycles after first out_valid -> out_data holds 25, in_ready=0, counters frozen. After release the full 144-sample sequence arrives with no loss or duplication.
- Abort: 100 ramp pixels, clear for one cycle with in_valid=1, then a full ramp frame -> outputs identical to the first scenario. The clear-cycle pixel is dropped.
- Robustness and throughput:
  - rstn pulsed low mid-frame -> out_valid=0 without waiting for a clock edge.
  - Then two back-to-back ramp frames with in_valid=1 throughout and out_ready=1 -> 288 outputs, out_last at outputs 144 and 288.

Source files
------------

// File: rtl/relu_maxpool_stage.sv
// relu_maxpool_stage
// ------------------
// Consumes the convolver's FEAT_SIZE x FEAT_SIZE feature-map stream in raster
// order. It optionally applies ReLU and then a 2x2 / stride-2 max-pool. The
// result is (FEAT_SIZE/2)^2 pooled samples on a valid/ready output.
//
// The horizontal pair max is formed on the odd column of each pair. On even
// rows it is parked in a half-width row buffer. On odd rows it is combined
// with the parked value to form the 2x2 maximum, which is registered out
// one cycle after the completing accept.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   clear      synchronous frame abort (counters to frame start, output dropped)
//   in_valid   upstream sample valid
//   in_ready   stage can accept (combinational: !out_valid || out_ready)
//   in_data    signed feature-map sample
//   out_valid  pooled sample valid
//   out_ready  downstream accepts
//   out_data   signed pooled sample
//   out_last   marks the final pooled sample of a frame
module relu_maxpool_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int FEAT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int HALF_SIZE = FEAT_SIZE / 2;
  localparam int CNT_W     = $clog2(FEAT_SIZE);
  localparam int IDX_W     = CNT_W - 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FEAT_SIZE - 1);

  if (FEAT_SIZE < 4 || (FEAT_SIZE % 2) != 0) begin : g_size_check
    $error("relu_maxpool_stage: FEAT_SIZE (%0d) must be even and >= 4", FEAT_SIZE);
  end

  logic [CNT_W-1:0]             col;
  logic [CNT_W-1:0]             row;
  logic [IDX_W-1:0]             pair_idx;
  logic signed [DATA_WIDTH-1:0] hold;
  logic signed [DATA_WIDTH-1:0] act;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] buf_rd;
  logic signed [DATA_WIDTH-1:0] pool_max;
  logic                         accept;
  logic                         col_wrap;

  // Entry k holds the horizontal max of columns 2k and 2k+1 from the last
  // even row.
  logic signed [DATA_WIDTH-1:0] rowbuf [HALF_SIZE];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col == LAST_IDX);
  assign pair_idx = col[CNT_W-1:1];

  // A negative sample is one whose sign bit is set.
  assign act      = (RELU_EN && in_data[DATA_WIDTH-1]) ? '0 : in_data;
  assign pair_max = (act > hold) ? act : hold;
  assign buf_rd   = rowbuf[pair_idx];
  assign pool_max = (pair_max > buf_rd) ? pair_max : buf_rd;

  // NOTE: sequential state uses non-blocking assignments only. A later
  // assignment in the same block overrides an earlier one, so a transfer that
  // clears out_valid is superseded by a new result on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (accept) begin
        col <= col_wrap ? '0 : col + 1'b1;
        if (col_wrap) begin
          row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        end
        if (!col[0]) begin
          hold <= act;
        end else if (row[0]) begin
          out_data  <= pool_max;
          out_valid <= 1'b1;
          out_last  <= (row == LAST_IDX) && col_wrap;
        end
      end
    end
  end

  // NOTE: the row buffer has no reset. Every entry is written on an even row
  // before the odd row reads it, so reset would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (accept && !clear && col[0] && !row[0]) begin
      rowbuf[pair_idx] <= pair_max;
    end
  end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Directed testbench for relu_maxpool_stage. Two instances share all inputs:
// one with ReLU enabled and one as a pure max-pool. Pooled outputs are
// captured on the falling edge, whenever a transfer is about to occur.
module tb_relu_maxpool_stage;

  localparam int DW   = 16;
  localparam int FS   = 24;
  localparam int HS   = 12;
  localparam int NOUT = HS * HS;

  localparam int K_RAMP = 0;
  localparam int K_NEG  = 1;
  localparam int K_WIN  = 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_ready = 1'b1;

  logic                 in_ready_r, in_ready_p;
  logic                 out_valid_r, out_valid_p;
  logic signed [DW-1:0] out_data_r, out_data_p;
  logic                 out_last_r, out_last_p;

  int checks = 0;
  int errors = 0;

  int q_r[$];
  int q_p[$];
  bit q_last[$];

  always #5 clk = ~clk;

  relu_maxpool_stage #(.DATA_WIDTH(DW), .IMAGE_SIZE(28), .KERNEL_SIZE(5), .RELU_EN(1'b1)) dut_relu (
    .clk(clk), .rstn(rstn), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .out_last(out_last_r)
  );

  relu_maxpool_stage #(.DATA_WIDTH(DW), .IMAGE_SIZE(28), .KERNEL_SIZE(5), .RELU_EN(1'b0)) dut_pure (
    .clk(clk), .rstn(rstn), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_p), .in_data(in_data),
    .out_valid(out_valid_p), .out_ready(out_ready), .out_data(out_data_p), .out_last(out_last_p)
  );

  // Inputs only change 1 time unit after a rising edge, so what is seen here
  // is what the next rising edge will act on.
  always @(negedge clk) begin
    if (rstn && out_valid_r && out_ready) begin
      q_r.push_back(int'(out_data_r));
      q_p.push_back(int'(out_data_p));
      q_last.push_back(out_last_r);
    end
  end

  function automatic int pixel_value(input int kind, input int r, input int c);
    int v;
    v = 0;
    case (kind)
      K_RAMP: v = r * FS + c;
      K_NEG:  v = -(r * FS + c + 1);
      default: begin
        if      (r == 0 && c == 0) v = -5;
        else if (r == 0 && c == 1) v = 3;
        else if (r == 1 && c == 0) v = 7;
        else if (r == 1 && c == 1) v = -100;
        else if (r == 0 && c == 2) v = -1;
        else if (r == 0 && c == 3) v = -2;
        else if (r == 1 && c == 2) v = -3;
        else if (r == 1 && c == 3) v = -4;
        else                       v = 0;
      end
    endcase
    return v;
  endfunction

  function automatic void clear_queues();
    q_r.delete();
    q_p.delete();
    q_last.delete();
  endfunction

  // Presents one sample and returns once it has been accepted. in_valid is
  // left high so consecutive calls stream without gaps.
  task automatic send_pixel(input int d);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready_r;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required an accept of %0d", d);
    end
  endtask

  task automatic send_frame(input int kind);
    for (int r = 0; r < FS; r++)
      for (int c = 0; c < FS; c++)
        send_pixel(pixel_value(kind, r, c));
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string tag);
    for (int i = 0; i < 100 && q_r.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (q_r.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, required %0d", tag, q_r.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  // Compares one frame of captured outputs starting at base. Each expected
  // value is formed from the pixel kind and the 2x2 window coordinates.
  task automatic verify_frame(input int kind, input int base, input string tag);
    int er, ep;
    for (int k = 0; k < NOUT; k++) begin
      int pr, pc;
      pr = k / HS;
      pc = k % HS;
      case (kind)
        K_RAMP: begin er = (2*pr+1)*FS + 2*pc+1; ep = er; end
        K_NEG:  begin er = 0; ep = -(2*pr*FS + 2*pc + 1); end
        default: begin
          er = (k == 0) ? 7 : 0;
          ep = (k == 0) ? 7 : (k == 1) ? -1 : 0;
        end
      endcase
      checks++;
      if (q_r[base+k] !== er) begin
        errors++;
        $display("FAIL %s_relu_data[%0d]: got %0d expected %0d", tag, k, q_r[base+k], er);
      end
      checks++;
      if (q_p[base+k] !== ep) begin
        errors++;
        $display("FAIL %s_pure_data[%0d]: got %0d expected %0d", tag, k, q_p[base+k], ep);
      end
      checks++;
      if (q_last[base+k] !== (k == NOUT-1)) begin
        errors++;
        $display("FAIL %s_last[%0d]: got %0d expected %0d", tag, k, q_last[base+k], (k == NOUT-1));
      end
    end
  endtask

  task automatic test_reset();
    #23;
    rstn = 1'b1;
    #1;
    checks++;
    if ({out_valid_r, out_last_r, out_valid_p, out_last_p} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {out_valid_r, out_last_r, out_valid_p, out_last_p});
    end
    checks++;
    if (out_data_r !== 16'sd0 || out_data_p !== 16'sd0) begin
      errors++;
      $display("FAIL reset_data: got %0d/%0d expected 0/0", out_data_r, out_data_p);
    end
    checks++;
    if (in_ready_r !== 1'b1 || in_ready_p !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b%b expected 11", in_ready_r, in_ready_p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    clear_queues();
    out_ready = 1'b1;
    send_frame(K_RAMP);
    wait_outputs(NOUT, "ramp");
    verify_frame(K_RAMP, 0, "ramp");
  endtask

  task automatic test_negative();
    clear_queues();
    send_frame(K_NEG);
    wait_outputs(NOUT, "neg");
    verify_frame(K_NEG, 0, "neg");
  endtask

  task automatic test_signed_window();
    clear_queues();
    send_frame(K_WIN);
    wait_outputs(NOUT, "win");
    verify_frame(K_WIN, 0, "win");
  endtask

  task automatic test_backpressure();
    clear_queues();
    out_ready = 1'b0;
    fork
      send_frame(K_RAMP);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          seen = out_valid_r;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL bp_first_valid: got out_valid=0 for 200 cycles, required 1");
        end
        for (int i = 0; i < 10; i++) begin
          checks++;
          if (out_valid_r !== 1'b1 || out_data_r !== 16'sd25 || in_ready_r !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall[%0d]: got valid=%b data=%0d in_ready=%b, required 1/25/0",
                     i, out_valid_r, out_data_r, in_ready_r);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_outputs(NOUT, "bp");
    verify_frame(K_RAMP, 0, "bp");
  endtask

  task automatic test_abort();
    clear_queues();
    for (int i = 0; i < 100; i++) send_pixel(i);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd1234;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid_r !== 1'b0 || out_last_r !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: got valid=%b last=%b expected 0/0", out_valid_r, out_last_r);
    end
    @(posedge clk);
    #1;
    clear_queues();
    send_frame(K_RAMP);
    wait_outputs(NOUT, "abort");
    verify_frame(K_RAMP, 0, "abort");
  endtask

  task automatic test_reset_then_back_to_back();
    clear_queues();
    out_ready = 1'b0;
    for (int i = 0; i < 26; i++) send_pixel(i);
    in_valid = 1'b0;
    checks++;
    if (out_valid_r !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_valid: got %b expected 1", out_valid_r);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid_r !== 1'b0 || out_valid_p !== 1'b0 || out_data_r !== 16'sd0 || in_ready_r !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b/%b data=%0d in_ready=%b, required 0/0/0/1",
               out_valid_r, out_valid_p, out_data_r, in_ready_r);
    end
    #3;
    rstn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear_queues();
    send_frame(K_RAMP);
    send_frame(K_RAMP);
    wait_outputs(2*NOUT, "b2b");
    verify_frame(K_RAMP, 0, "b2b0");
    verify_frame(K_RAMP, NOUT, "b2b1");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_signed_window();
    test_backpressure();
    test_abort();
    test_reset_then_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
